// File: rtl/i2c_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_resp_pkg                                                               |
// | Shared state encoding and register map for the I2C gyro responder.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package i2c_resp_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WRITE     = 4'd5,
        WRITE_ACK = 4'd6,
        READ      = 4'd7,
        MACK      = 4'd8
    } state_t;

    localparam logic [7:0] REG_GYRO_CFG = 8'h1B;
    localparam logic [7:0] REG_GX_H     = 8'h43;
    localparam logic [7:0] REG_GX_L     = 8'h44;
    localparam logic [7:0] REG_GY_H     = 8'h45;
    localparam logic [7:0] REG_GY_L     = 8'h46;
    localparam logic [7:0] REG_GZ_H     = 8'h47;
    localparam logic [7:0] REG_GZ_L     = 8'h48;
    localparam logic [7:0] REG_PWR_MGMT = 8'h6B;
    localparam logic [7:0] REG_WHO_AM_I = 8'h75;

    localparam logic [7:0] PWR_MGMT_RST = 8'h40;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_line_filter                                                            |
// | Two-flop synchroniser plus majority-free glitch filter with edge pulses.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-2:0] r_hist;
    logic [FILTER_LEN-1:0] w_win;
    logic                  r_level;
    logic                  r_rise;
    logic                  r_fall;

    // Window = newest synchronised sample plus the previous FILTER_LEN-1.
    assign w_win = {r_hist, r_sync[1]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sync  <= 2'b11;
            r_hist  <= '1;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_hist <= w_win[FILTER_LEN-2:0];
            r_rise <= (&w_win) & ~r_level;
            r_fall <= ~(|w_win) & r_level;
            if (&w_win) begin
                r_level <= 1'b1;
            end else if (~(|w_win)) begin
                r_level <= 1'b0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/i2c_gyro_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_gyro_responder                                                         |
// | I2C target emulating the MPU-6050 registers polled by the gyro reader.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module i2c_gyro_responder
    import i2c_resp_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter int         FILTER_LEN  = 3,
    parameter int         HOLD_CYCLES = 4,
    parameter logic [7:0] WHO_AM_I    = 8'h68
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               scl_in,
    input  logic               sda_in,
    output logic               sda_oe_out,
    input  logic signed [15:0] gx_in,
    input  logic signed [15:0] gy_in,
    input  logic signed [15:0] gz_in,
    input  logic               sample_valid_in,
    output logic [7:0]         pwr_mgmt_out,
    output logic [7:0]         gyro_cfg_out,
    output logic               wr_strobe_out,
    output logic               busy_out
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_in(clk_in), .rst_in(rst_in), .i_raw(scl_in),
        .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_in(clk_in), .rst_in(rst_in), .i_raw(sda_in),
        .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    state_t      r_state, w_state_next;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift, r_tx, r_ptr, r_pwr, r_cfg, r_hold;
    logic [15:0] r_gx, r_gy, r_gz, r_sx, r_sy, r_sz;
    logic        r_sda_oe, r_mack_nack, r_wr_pend, r_wr_strobe, r_busy;
    logic        w_start, w_stop, w_byte_done, w_addr_hit, w_drive_tgt;
    logic [7:0]  w_rd_data;

    // Our own drive shows up on the filtered SDA; never decode it as a bus condition.
    assign w_start     = w_sda_fall & w_scl_lvl & ~r_sda_oe;
    assign w_stop      = w_sda_rise & w_scl_lvl & ~r_sda_oe;
    assign w_byte_done = (r_bit_cnt == 4'd8);
    assign w_addr_hit  = (r_shift[7:1] == DEV_ADDR);

    always_comb begin
        w_rd_data = 8'h00;
        case (r_ptr)
            REG_GYRO_CFG: w_rd_data = r_cfg;
            REG_GX_H:     w_rd_data = r_sx[15:8];
            REG_GX_L:     w_rd_data = r_sx[7:0];
            REG_GY_H:     w_rd_data = r_sy[15:8];
            REG_GY_L:     w_rd_data = r_sy[7:0];
            REG_GZ_H:     w_rd_data = r_sz[15:8];
            REG_GZ_L:     w_rd_data = r_sz[7:0];
            REG_PWR_MGMT: w_rd_data = r_pwr;
            REG_WHO_AM_I: w_rd_data = WHO_AM_I;
            default:      w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_drive_tgt  = 1'b0;
        case (r_state)
            ADDR_ACK, PTR_ACK, WRITE_ACK: w_drive_tgt = 1'b1;
            READ:                         w_drive_tgt = ~r_tx[7];
            default:                      w_drive_tgt = 1'b0;
        endcase
        if (w_stop) begin
            w_state_next = IDLE;
        end else if (w_start) begin
            w_state_next = ADDR;
        end else if (w_scl_fall) begin
            case (r_state)
                ADDR:      if (w_byte_done) w_state_next = w_addr_hit ? ADDR_ACK : IDLE;
                ADDR_ACK:  w_state_next = r_shift[0] ? READ : PTR;
                PTR:       if (w_byte_done) w_state_next = PTR_ACK;
                PTR_ACK:   w_state_next = WRITE;
                WRITE:     if (w_byte_done) w_state_next = WRITE_ACK;
                WRITE_ACK: w_state_next = WRITE;
                READ:      if (w_byte_done) w_state_next = MACK;
                MACK:      w_state_next = r_mack_nack ? IDLE : READ;
                default:   w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_ptr       <= '0;
            r_pwr       <= PWR_MGMT_RST;
            r_cfg       <= '0;
            r_hold      <= '0;
            r_gx        <= '0;
            r_gy        <= '0;
            r_gz        <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_sz        <= '0;
            r_sda_oe    <= 1'b0;
            r_mack_nack <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_strobe <= r_wr_pend;
            r_wr_pend   <= 1'b0;
            if (sample_valid_in) begin
                r_gx <= gx_in;
                r_gy <= gy_in;
                r_gz <= gz_in;
            end
            // SDA changes are deferred until the hold timer started at SCL fall expires.
            if (r_hold != 8'd0) begin
                r_hold <= r_hold - 8'd1;
                if (r_hold == 8'd1) begin
                    r_sda_oe <= w_drive_tgt;
                end
            end
            if (w_start || w_stop) begin
                r_busy    <= w_start;
                r_bit_cnt <= '0;
                r_hold    <= '0;
                r_sda_oe  <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    ADDR, PTR, WRITE: begin
                        r_shift   <= {r_shift[6:0], w_sda_lvl};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    READ:    r_bit_cnt <= r_bit_cnt + 4'd1;
                    MACK:    r_mack_nack <= w_sda_lvl;
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                r_hold <= 8'(HOLD_CYCLES);
                if (w_state_next != r_state) begin
                    r_bit_cnt <= '0;
                end
                case (r_state)
                    ADDR: begin
                        if (w_byte_done && w_addr_hit && r_shift[0]) begin
                            r_sx <= r_gx;
                            r_sy <= r_gy;
                            r_sz <= r_gz;
                        end
                    end
                    ADDR_ACK: if (r_shift[0]) r_tx <= w_rd_data;
                    PTR:      if (w_byte_done) r_ptr <= r_shift;
                    WRITE: begin
                        if (w_byte_done) begin
                            if (r_ptr == REG_GYRO_CFG) r_cfg <= r_shift;
                            if (r_ptr == REG_PWR_MGMT) r_pwr <= r_shift;
                            r_ptr     <= r_ptr + 8'd1;
                            r_wr_pend <= 1'b1;
                        end
                    end
                    READ: begin
                        if (w_byte_done) begin
                            r_ptr <= r_ptr + 8'd1;
                        end else begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                    end
                    MACK:    if (!r_mack_nack) r_tx <= w_rd_data;
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe_out    = r_sda_oe;
    assign pwr_mgmt_out  = r_pwr;
    assign gyro_cfg_out  = r_cfg;
    assign wr_strobe_out = r_wr_strobe;
    assign busy_out      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_gyro_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2c_gyro_responder                                                      |
// | Directed + randomised bus transactions against a register-level model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_i2c_gyro_responder;

    localparam int         H   = 16;
    localparam logic [6:0] DEV = 7'h68;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl   = 1'b1;
    logic        m_oe  = 1'b0;
    logic        sv    = 1'b0;
    logic [15:0] gx    = '0;
    logic [15:0] gy    = '0;
    logic [15:0] gz    = '0;
    logic        sda_oe, sda_line, wr_strobe, busy;
    logic [7:0]  pwr, cfg;

    int   checks  = 0;
    int   errors  = 0;
    int   wr_hi   = 0;
    int   wr_rise = 0;
    int   oe_hi   = 0;
    logic wr_d    = 1'b0;

    logic [7:0]  m_pwr, m_cfg, m_ptr;
    logic [15:0] m_live [3];
    logic [15:0] m_snap [3];
    int          exp_wr = 0;
    logic [7:0]  wbuf [8];

    always #5 clk = ~clk;
    assign sda_line = ~(m_oe | sda_oe);

    i2c_gyro_responder dut (
        .clk_in(clk), .rst_in(rst_n), .scl_in(scl), .sda_in(sda_line),
        .sda_oe_out(sda_oe), .gx_in(gx), .gy_in(gy), .gz_in(gz),
        .sample_valid_in(sv), .pwr_mgmt_out(pwr), .gyro_cfg_out(cfg),
        .wr_strobe_out(wr_strobe), .busy_out(busy)
    );

    always @(posedge clk) begin
        wr_d <= wr_strobe;
        if (wr_strobe) wr_hi <= wr_hi + 1;
        if (wr_strobe && !wr_d) wr_rise <= wr_rise + 1;
        if (sda_oe) oe_hi <= oe_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pwr = 8'h40;
        m_cfg = 8'h00;
        m_ptr = 8'h00;
        for (int i = 0; i < 3; i++) begin
            m_live[i] = '0;
            m_snap[i] = '0;
        end
    endtask

    function automatic logic [7:0] model_reg(input logic [7:0] a);
        int          k;
        logic [15:0] w;
        if (a == 8'h1B) return m_cfg;
        if (a == 8'h6B) return m_pwr;
        if (a == 8'h75) return 8'h68;
        if (a >= 8'h43 && a <= 8'h48) begin
            k = int'(a) - 'h43;
            w = m_snap[k / 2];
            return (k % 2 == 0) ? w[15:8] : w[7:0];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] pick_ptr();
        case ($urandom_range(0, 5))
            0:       return 8'h1B;
            1:       return 8'h6B;
            2:       return 8'h75;
            3:       return 8'h43 + 8'($urandom_range(0, 5));
            4:       return 8'hFE;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        gx = x; gy = y; gz = z; sv = 1'b1;
        tick(1);
        sv = 1'b0;
        m_live[0] = x; m_live[1] = y; m_live[2] = z;
    endtask

    task automatic bus_start();
        m_oe = 1'b0; tick(H / 2);
        scl  = 1'b1; tick(H);
        m_oe = 1'b1; tick(H);
        scl  = 1'b0; tick(H / 2);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; tick(H / 2);
        scl  = 1'b1; tick(H);
        m_oe = 1'b0; tick(H);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_oe = ~b; tick(H / 2);
        scl  = 1'b1; tick(H / 2);
        s    = sda_line; tick(H / 2);
        scl  = 1'b0; tick(H / 2);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack_lvl, input string tag);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        check(tag, 32'(s), 32'(exp_ack_lvl));
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
    endtask

    task automatic do_write(input logic [7:0] ptr, input int n);
        bus_start();
        check("busy_after_start", 32'(busy), 32'd1);
        wr_byte({DEV, 1'b0}, 1'b0, "ack_addr_w");
        wr_byte(ptr, 1'b0, "ack_ptr");
        m_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            wr_byte(wbuf[i], 1'b0, "ack_data");
            if (m_ptr == 8'h1B) m_cfg = wbuf[i];
            if (m_ptr == 8'h6B) m_pwr = wbuf[i];
            m_ptr = m_ptr + 8'd1;
            exp_wr++;
        end
        bus_stop();
        check("pwr_mgmt", 32'(pwr), 32'(m_pwr));
        check("gyro_cfg", 32'(cfg), 32'(m_cfg));
        check("wr_strobe_cycles", 32'(wr_hi), 32'(exp_wr));
        check("wr_strobe_pulses", 32'(wr_rise), 32'(exp_wr));
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n, input logic mid);
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            wr_byte({DEV, 1'b0}, 1'b0, "ack_addr_w");
            wr_byte(ptr, 1'b0, "ack_ptr");
            m_ptr = ptr;
            bus_start();
        end
        wr_byte({DEV, 1'b1}, 1'b0, "ack_addr_r");
        m_snap = m_live;
        for (int i = 0; i < n; i++) begin
            if (mid && i == 2) strobe(16'($urandom), 16'($urandom), 16'($urandom));
            rd_byte(i == n - 1, d);
            check("rd_data", 32'(d), 32'(model_reg(m_ptr)));
            m_ptr = m_ptr + 8'd1;
        end
        bus_stop();
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    initial begin
        int oe0;
        int kind;
        int n;
        model_reset();
        tick(4);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_pwr", 32'(pwr), 32'h40);
        check("rst_cfg", 32'(cfg), 32'h00);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(4);

        wbuf[0] = 8'h00;
        do_write(8'h6B, 1);
        wbuf[0] = 8'h11; wbuf[1] = 8'h18;
        do_write(8'h1A, 2);

        strobe(16'h1234, 16'hABCD, 16'h8001);
        do_read(1'b1, 8'h43, 6, 1'b0);

        strobe(16'h0F0E, 16'h7654, 16'hC3A5);
        do_read(1'b1, 8'h43, 6, 1'b1);

        // Foreign address: no ACK and no drive for the rest of the transfer.
        oe0 = oe_hi;
        bus_start();
        wr_byte({7'h69, 1'b0}, 1'b1, "nak_addr");
        wr_byte(8'h6B, 1'b1, "nodrive_ptr");
        wr_byte(8'h55, 1'b1, "nodrive_data");
        bus_stop();
        check("no_drive_foreign", 32'(oe_hi - oe0), 32'd0);
        check("pwr_unchanged", 32'(pwr), 32'(m_pwr));
        check("cfg_unchanged", 32'(cfg), 32'(m_cfg));

        do_read(1'b1, 8'h75, 1, 1'b0);
        do_read(1'b1, 8'hFF, 2, 1'b0);
        do_read(1'b0, 8'h00, 1, 1'b0);

        for (int t = 0; t < 10; t++) begin
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) strobe(16'($urandom), 16'($urandom), 16'($urandom));
            if (kind == 0) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(pick_ptr(), n);
            end else if (kind == 3) begin
                do_read(1'b0, 8'h00, $urandom_range(1, 2), 1'b0);
            end else begin
                n = $urandom_range(1, 4);
                do_read(1'b1, pick_ptr(), n, (n >= 3) && ($urandom_range(0, 1) == 1));
            end
        end

        // Reset while the responder is holding a 0 data bit on SDA.
        do_write(8'h75, 0);
        bus_start();
        wr_byte({DEV, 1'b1}, 1'b0, "ack_addr_r");
        tick(6);
        check("drive_read_bit7", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_release", 32'(sda_oe), 32'd0);
        tick(3);
        rst_n = 1'b1;
        model_reset();
        m_oe = 1'b0;
        tick(H);
        check("post_rst_pwr", 32'(pwr), 32'h40);
        check("post_rst_busy", 32'(busy), 32'd0);
        do_read(1'b1, 8'h6B, 1, 1'b0);
        do_read(1'b1, 8'h75, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
